// File: rtl/padctl_pkg.sv
// Shared types and constants for the padctl strap controller and pad mux.
// Safe levels below are what the pad mux drives while pad_quiesce_o is high.
package padctl_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE   = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_GUARD    = 2'd2,
        ST_LOCKED   = 2'd3
    } strap_state_e;

    typedef enum logic {
        MODE_SPI  = 1'b0,
        MODE_JTAG = 1'b1
    } pad_mode_e;

    localparam logic SAFE_CSB     = 1'b1;
    localparam logic SAFE_TRST_N  = 1'b0;
    localparam logic SAFE_SRST_N  = 1'b0;
    localparam logic SAFE_DPS2_OE = 1'b0;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/padctl_sync2.sv
// Two-flop synchroniser for one asynchronous strap pad, reset to 0.
module padctl_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/padctl_strap_ctrl.sv
// Boot strap sampler: settle, debounce, guard, then release the pad mux.
// Define PADCTL_STRAP_RESAMPLE_EN to allow software-requested re-sampling.
module padctl_strap_ctrl
    import padctl_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GUARD_CYCLES    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strap_jtag_spi_n_i,
    input  logic strap_boot_i,
    input  logic resample_req_i,
    output logic resample_ack_o,
    output logic jtag_spi_n_o,
    output logic boot_strap_o,
    output logic pad_quiesce_o,
    output logic strap_valid_o
);

    localparam int CNT_MAX = maxOf3(SETTLE_CYCLES, DEBOUNCE_CYCLES, GUARD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);

    logic             w_jtagSync;
    logic             w_bootSync;
    logic [1:0]       w_pair;
    logic [CNT_W-1:0] w_cntInc;
    logic             w_reqAccept;

    strap_state_e     r_state;
    strap_state_e     w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_capture;
    pad_mode_e        r_mode;
    logic             r_boot;

    padctl_sync2 u_syncJtag (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (strap_jtag_spi_n_i),
        .o_q   (w_jtagSync)
    );

    padctl_sync2 u_syncBoot (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (strap_boot_i),
        .o_q   (w_bootSync)
    );

    assign w_pair   = {w_jtagSync, w_bootSync};
    assign w_cntInc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

`ifdef PADCTL_STRAP_RESAMPLE_EN
    logic r_ack;
    logic r_pending;

    // The ack cycle itself ignores the request so a held request restarts one cycle later.
    assign w_reqAccept = resample_req_i && !r_ack;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_ack <= (r_state != ST_LOCKED) && (w_nextState == ST_LOCKED) && r_pending;
            if ((r_state == ST_LOCKED) && (w_nextState == ST_SETTLE)) begin
                r_pending <= 1'b1;
            end else if (w_nextState == ST_LOCKED) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign resample_ack_o = r_ack;
`else
    logic w_unusedReq;
    assign w_unusedReq    = resample_req_i;
    assign w_reqAccept    = 1'b0;
    assign resample_ack_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_SETTLE:   if (r_cnt == SETTLE_LAST) w_nextState = ST_DEBOUNCE;
            ST_DEBOUNCE: if ((w_pair == r_capture) && (r_cnt == DEB_LAST)) w_nextState = ST_GUARD;
            ST_GUARD:    if (r_cnt == GUARD_LAST) w_nextState = ST_LOCKED;
            ST_LOCKED:   if (w_reqAccept) w_nextState = ST_SETTLE;
            default:     w_nextState = ST_SETTLE;
        endcase
    end

    always_comb begin
        pad_quiesce_o = (r_state != ST_LOCKED);
        strap_valid_o = (r_state == ST_LOCKED);
    end

    // Shared counter restarts on every state change; commit happens only on DEBOUNCE->GUARD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_capture <= 2'b00;
            r_mode    <= MODE_SPI;
            r_boot    <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (w_nextState == ST_DEBOUNCE) begin
                        r_capture <= w_pair;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_pair != r_capture) begin
                        r_capture <= w_pair;
                        r_cnt     <= '0;
                    end else if (w_nextState == ST_GUARD) begin
                        r_mode <= pad_mode_e'(r_capture[1]);
                        r_boot <= r_capture[0];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                ST_GUARD: begin
                    r_cnt <= (w_nextState == ST_LOCKED) ? '0 : w_cntInc;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign jtag_spi_n_o = r_mode;
    assign boot_strap_o = r_boot;

endmodule
